pio_in_edge_capture: RTL and testbench



---
 rtl/pio_in_edge_capture.sv | 179 +++++++++++++++++
 tb/tb_pio_in_edge_capture.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pio_in_edge_capture.sv
// Avalon-MM input PIO: synchronizes in_port, captures edges in a sticky register, raises a maskable irq.
// Optional input debounce filter is built when PIO_IN_DEBOUNCE_EN is defined.
module pio_in_edge_capture #(
    parameter int WIDTH           = 10,
    parameter int SYNC_STAGES     = 2,
    parameter int EDGE_TYPE       = 0,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic             read_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_MASK    = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;

`ifdef PIO_IN_DEBOUNCE_EN
    localparam int CNT_W        = $clog2(DEBOUNCE_CYCLES);
    localparam int PRIME_CYCLES = SYNC_STAGES + 1 + DEBOUNCE_CYCLES + 1;
`else
    localparam int PRIME_CYCLES = SYNC_STAGES + 1;
`endif
    localparam int PRIME_W = $clog2(PRIME_CYCLES + 1);
    localparam logic [PRIME_W-1:0] PRIME_DONE = PRIME_W'(PRIME_CYCLES);

    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
        $error("pio_in_edge_capture: SYNC_STAGES must be 2..4");
    end
    if (EDGE_TYPE < 0 || EDGE_TYPE > 2) begin : g_bad_edge
        $error("pio_in_edge_capture: EDGE_TYPE must be 0, 1 or 2");
    end
    if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 65535) begin : g_bad_debounce
        $error("pio_in_edge_capture: DEBOUNCE_CYCLES must be 2..65535");
    end
    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
        $error("pio_in_edge_capture: WIDTH must be 1..32");
    end

    function automatic logic [31:0] zext(input logic [WIDTH-1:0] v);
        logic [31:0] r;
        r          = '0;
        r[WIDTH-1:0] = v;
        return r;
    endfunction

    logic [WIDTH-1:0] sync_ff [SYNC_STAGES];
    logic [WIDTH-1:0] sync;
    logic [WIDTH-1:0] filt;
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] cap;
    logic [WIDTH-1:0] mask;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] edge_hit;
    logic [WIDTH-1:0] cap_clr;
    logic [PRIME_W-1:0] prime_cnt;
    logic             primed;
    logic             wr_en;
    logic             rd_en;

    // Stage: metastability synchronizer
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_ff[i] <= '0;
            end
        end else begin
            sync_ff[0] <= in_port;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_ff[i] <= sync_ff[i-1];
            end
        end
    end

    assign sync = sync_ff[SYNC_STAGES-1];

`ifdef PIO_IN_DEBOUNCE_EN
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync_d;
    logic [CNT_W-1:0] cnt;

    // Stage: debounce; filt only follows sync after a full quiet window with no change this cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_d <= '0;
            cnt    <= '0;
            filt   <= '0;
        end else begin
            sync_d <= sync;
            if (sync != sync_d) begin
                cnt <= '0;
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + CNT_W'(1);
            end
            if (cnt == CNT_MAX && sync == sync_d) begin
                filt <= sync;
            end
        end
    end
`else
    assign filt = sync;
`endif

    // Stage: priming counter holds off detection until the input path carries post-reset data
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prime_cnt <= '0;
        end else if (!primed) begin
            prime_cnt <= prime_cnt + PRIME_W'(1);
        end
    end

    assign primed = (prime_cnt == PRIME_DONE);

    always_comb begin
        rise     = filt & ~prev;
        fall     = ~filt & prev;
        edge_hit = '0;
        if (primed) begin
            if (EDGE_TYPE == 0) begin
                edge_hit = rise;
            end else if (EDGE_TYPE == 1) begin
                edge_hit = fall;
            end else begin
                edge_hit = rise | fall;
            end
        end
    end

    assign wr_en   = chipselect & ~write_n;
    assign rd_en   = chipselect & ~read_n;
    assign cap_clr = (wr_en && address == ADDR_EDGECAP) ? writedata[WIDTH-1:0] : '0;

    // Stage: edge history, sticky capture and mask; a new edge beats a same-cycle clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev <= '0;
            cap  <= '0;
            mask <= '0;
        end else begin
            prev <= filt;
            cap  <= (cap & ~cap_clr) | edge_hit;
            if (wr_en && address == ADDR_MASK) begin
                mask <= writedata[WIDTH-1:0];
            end
        end
    end

    // Stage: registered read port, holds its value between reads
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            readdata <= '0;
        end else if (rd_en) begin
            case (address)
                ADDR_DATA:    readdata <= zext(filt);
                ADDR_MASK:    readdata <= zext(mask);
                ADDR_EDGECAP: readdata <= zext(cap);
                default:      readdata <= '0;
            endcase
        end
    end

    assign irq = |(cap & mask);

    if (WIDTH < 32) begin : g_wdata_upper
        logic unused_wdata_upper;
        assign unused_wdata_upper = ^writedata[31:WIDTH];
    end

endmodule

// File: tb/tb_pio_in_edge_capture.sv
// Self-checking bench for pio_in_edge_capture: rising-edge and any-edge instances on a shared bus.
`timescale 1ns/1ps
module tb_pio_in_edge_capture;

    localparam int W = 10;
    localparam int S = 2;
`ifdef PIO_IN_DEBOUNCE_EN
    localparam int SETTLE = 30;
`else
    localparam int SETTLE = 10;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic [1:0]    address;
    logic          chipselect;
    logic          write_n;
    logic          read_n;
    logic [31:0]   writedata;
    logic [W-1:0]  in_port;
    logic [31:0]   rd0, rd2;
    logic          irq0, irq2;

    int passed = 0;
    int total  = 0;

    // Reference model: delay line of sampled inputs plus architectural registers
    logic [W-1:0] hist[$];
    int           n_edges;
    logic [W-1:0] m_cap0, m_cap2, m_mask;
    logic [31:0]  m_rd0, m_rd2;

    always #5 clk = ~clk;

    pio_in_edge_capture #(.WIDTH(W), .SYNC_STAGES(S), .EDGE_TYPE(0), .DEBOUNCE_CYCLES(16)) dut (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .read_n(read_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd0), .irq(irq0)
    );

    pio_in_edge_capture #(.WIDTH(W), .SYNC_STAGES(S), .EDGE_TYPE(2), .DEBOUNCE_CYCLES(16)) dut_any (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .read_n(read_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd2), .irq(irq2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < S + 2; i++) hist.push_back('0);
        n_edges = 0;
        m_cap0 = '0; m_cap2 = '0; m_mask = '0;
        m_rd0 = '0;  m_rd2 = '0;
    endtask

    task automatic model_step();
        logic [W-1:0] f, p, clr, rise, fall;
        logic         primed;
        n_edges++;
        hist.push_front(in_port);
        f = hist[S];
        p = hist[S+1];
        void'(hist.pop_back());
        primed = (n_edges > S + 1);
        rise = primed ? (f & ~p) : '0;
        fall = primed ? (~f & p) : '0;
        if (chipselect && !read_n) begin
            case (address)
                2'd0:    begin m_rd0 = 32'(f);      m_rd2 = 32'(f);      end
                2'd2:    begin m_rd0 = 32'(m_mask); m_rd2 = 32'(m_mask); end
                2'd3:    begin m_rd0 = 32'(m_cap0); m_rd2 = 32'(m_cap2); end
                default: begin m_rd0 = '0;          m_rd2 = '0;          end
            endcase
        end
        clr = (chipselect && !write_n && address == 2'd3) ? writedata[W-1:0] : '0;
        m_cap0 = (m_cap0 & ~clr) | rise;
        m_cap2 = (m_cap2 & ~clr) | rise | fall;
        if (chipselect && !write_n && address == 2'd2) m_mask = writedata[W-1:0];
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
`ifndef PIO_IN_DEBOUNCE_EN
        check("model_rd_rise", rd0, m_rd0);
        check("model_rd_any", rd2, m_rd2);
        check("model_irq_rise", 32'(irq0), 32'(|(m_cap0 & m_mask)));
        check("model_irq_any", 32'(irq2), 32'(|(m_cap2 & m_mask)));
`endif
    endtask

    task automatic bus_idle();
        chipselect = 1'b0; write_n = 1'b1; read_n = 1'b1;
    endtask

    task automatic do_write(input logic [1:0] a, input logic [31:0] d);
        chipselect = 1'b1; write_n = 1'b0; read_n = 1'b1; address = a; writedata = d;
        tick();
        bus_idle();
    endtask

    task automatic do_read(input logic [1:0] a);
        chipselect = 1'b1; write_n = 1'b1; read_n = 1'b0; address = a;
        tick();
        bus_idle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        bus_idle();
        address = '0; writedata = '0;
        in_port = 10'h3FF;
        reset   = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_readdata", rd0, 32'h0);
        check("reset_irq", 32'(irq0), 32'h0);
        reset = 1'b0;
        model_reset();

        // Inputs high through reset must not leave a spurious capture
        repeat (SETTLE) tick();
        do_read(2'd3);
        check("prime_edgecap_rise", rd0, 32'h0);
        check("prime_edgecap_any", rd2, 32'h0);
        do_read(2'd0);
        check("prime_data", rd0, 32'h3FF);
        check("prime_irq", 32'(irq0 | irq2), 32'h0);

`ifndef PIO_IN_DEBOUNCE_EN
        // Rising edge on bit0 with mask bit0, then clear
        in_port = '0;
        repeat (4) tick();
        do_write(2'd3, 32'hFFFF_FFFF);
        do_write(2'd2, 32'h1);
        in_port = 10'h001;
        tick();
        check("lat_edge1_irq", 32'(irq0), 32'h0);
        tick();
        check("lat_edge2_irq", 32'(irq0), 32'h0);
        tick();
        check("lat_edge3_irq", 32'(irq0), 32'h1);
        do_read(2'd3);
        check("bit0_edgecap", rd0, 32'h1);
        do_write(2'd3, 32'h1);
        check("clear_irq", 32'(irq0), 32'h0);

        // Clear on the cycle the bit3 edge is detected: edge wins
        in_port = 10'h009;
        tick();
        tick();
        chipselect = 1'b1; write_n = 1'b0; address = 2'd3; writedata = 32'h8;
        tick();
        bus_idle();
        do_read(2'd3);
        check("clear_vs_edge_bit3", 32'(rd0[3]), 32'h1);

        // All bits captured with mask 0, then unmask bit9
        in_port = '0;
        repeat (4) tick();
        do_write(2'd2, 32'h0);
        do_write(2'd3, 32'hFFFF_FFFF);
        in_port = 10'h3FF;
        repeat (4) tick();
        do_read(2'd3);
        check("all_bits_edgecap", rd0, 32'h3FF);
        check("mask0_irq", 32'(irq0), 32'h0);
        do_write(2'd2, 32'h200);
        check("unmask_irq", 32'(irq0), 32'h1);

        // Any-edge instance: falling edge alone re-sets bit5
        do_write(2'd2, 32'h0);
        in_port = '0;
        repeat (4) tick();
        in_port = 10'h020;
        repeat (4) tick();
        do_read(2'd3);
        check("any_rise_bit5", 32'(rd2[5]), 32'h1);
        do_write(2'd3, 32'hFFFF_FFFF);
        in_port = '0;
        repeat (4) tick();
        do_read(2'd3);
        check("any_fall_bit5", rd2, 32'h020);
        check("rise_ignores_fall", rd0, 32'h0);

        // Randomized traffic against the model
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 3) == 0) in_port = W'($urandom);
            case ($urandom_range(0, 3))
                0: bus_idle();
                1, 3: begin
                    chipselect = 1'b1; write_n = 1'b1; read_n = 1'b0;
                    address = 2'($urandom_range(0, 3));
                end
                default: begin
                    chipselect = 1'b1; write_n = 1'b0; read_n = 1'b1;
                    address = 2'($urandom_range(0, 3)); writedata = $urandom;
                end
            endcase
            tick();
        end
        bus_idle();

        // Asynchronous reset mid-operation
        do_write(2'd2, 32'hFFFF_FFFF);
        in_port = '0;
        repeat (4) tick();
        in_port = 10'h3FF;
        repeat (4) tick();
        check("pre_reset_irq", 32'(irq0), 32'h1);
        do_read(2'd3);
        #2 reset = 1'b1;
        #1;
        check("async_reset_readdata", rd0, 32'h0);
        check("async_reset_irq", 32'(irq0 | irq2), 32'h0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        repeat (SETTLE) tick();
        do_read(2'd3);
        check("rearm_edgecap", rd0, 32'h0);
        do_read(2'd2);
        check("rearm_mask", rd0, 32'h0);
`else
        // Debounce: short glitch is filtered out
        in_port = '0;
        repeat (40) tick();
        do_write(2'd3, 32'hFFFF_FFFF);
        in_port = 10'h002;
        repeat (10) tick();
        in_port = '0;
        repeat (40) tick();
        do_read(2'd0);
        check("db_glitch_data", rd0, 32'h0);
        do_read(2'd3);
        check("db_glitch_edgecap", rd0, 32'h0);
        check("db_glitch_edgecap_any", rd2, 32'h0);

        // Debounce: held level reaches DATA after sync + window + 1 edges
        in_port = 10'h002;
        repeat (S + 16) tick();
        do_read(2'd0);
        check("db_level_data_early", rd0, 32'h0);
        do_read(2'd0);
        check("db_level_data", rd0, 32'h2);
        do_read(2'd3);
        check("db_level_edgecap", rd0, 32'h2);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
